// File: rtl/wb_queue.sv
// ============================================================================
// wb_queue : ALU/LSU writeback arbiter with a load buffer and starvation guard
// Optional macro WB_QUEUE_BYPASS_EN lets loads skip an empty buffer. Rev 1.0
// ============================================================================
`default_nettype none

module wb_queue #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_alu_valid,
  input  logic [4:0]  i_alu_rd_addr,
  input  logic [31:0] i_alu_rd_data,
  output logic        o_alu_ready,
  input  logic        i_lsu_valid,
  input  logic [4:0]  i_lsu_rd_addr,
  input  logic [31:0] i_lsu_rd_data,
  output logic        o_lsu_ready,
  output logic [4:0]  o_rd_addr,
  output logic [31:0] o_rd_data,
  output logic        o_rd_wren,
  output logic [31:0] o_pending,
  output logic        o_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_FULL = DEPTH[AW:0];
  localparam logic [3:0]  C_STARVE_LIMIT = STARVE_LIMIT[3:0];

  logic [4:0]       r_addr_mem [DEPTH];
  logic [31:0]      r_data_mem [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [3:0]       r_starve;

  logic        w_empty;
  logic        w_full;
  logic        w_starve_hit;
  logic        w_alu_xfer;
  logic        w_lsu_xfer;
  logic        w_pop;
  logic        w_push;
  logic        w_bypass;
  logic [31:0] w_pending;

  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == C_FULL);
  assign w_starve_hit = (r_starve == C_STARVE_LIMIT);

  // Handshakes are forced open while in reset; transfers are then ignored.
  assign o_alu_ready = !w_starve_hit || !i_rst;
  assign o_lsu_ready = !w_full || !i_rst;

  assign w_alu_xfer = i_rst && i_alu_valid && !w_starve_hit;
  assign w_lsu_xfer = i_rst && i_lsu_valid && !w_full;
  assign w_pop      = !w_empty && !w_alu_xfer;

`ifdef WB_QUEUE_BYPASS_EN
  assign w_bypass = w_lsu_xfer && w_empty && !w_alu_xfer && (i_lsu_rd_addr != 5'd0);
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push = w_lsu_xfer && (i_lsu_rd_addr != 5'd0) && !w_bypass;

  always_comb begin
    w_pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i]) w_pending[r_addr_mem[i]] = 1'b1;
    end
  end

  assign o_pending = i_rst ? w_pending : 32'd0;
  assign o_busy    = i_rst && !w_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_addr_mem[r_wr_ptr] <= i_lsu_rd_addr;
      r_data_mem[r_wr_ptr] <= i_lsu_rd_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_vld     <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_starve  <= '0;
      o_rd_wren <= 1'b0;
      o_rd_addr <= 5'd0;
      o_rd_data <= 32'd0;
    end else begin
      if (w_pop) begin
        r_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= r_rd_ptr + 1'b1;
      end
      if (w_push) begin
        r_vld[r_wr_ptr] <= 1'b1;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      // Counts ALU wins over a waiting load; any pop or empty buffer clears it.
      r_starve <= (!w_empty && w_alu_xfer) ? r_starve + 1'b1 : 4'd0;

      if (w_alu_xfer) begin
        o_rd_wren <= (i_alu_rd_addr != 5'd0);
        o_rd_addr <= i_alu_rd_addr;
        o_rd_data <= i_alu_rd_data;
      end else if (w_pop) begin
        o_rd_wren <= 1'b1;
        o_rd_addr <= r_addr_mem[r_rd_ptr];
        o_rd_data <= r_data_mem[r_rd_ptr];
      end else if (w_bypass) begin
        o_rd_wren <= 1'b1;
        o_rd_addr <= i_lsu_rd_addr;
        o_rd_data <= i_lsu_rd_data;
      end else begin
        o_rd_wren <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_queue.sv
// tb_wb_queue : randomized check of wb_queue against a queue-based writeback model
`default_nettype none

module tb_wb_queue;

  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 3;
`ifdef WB_QUEUE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        lsu_valid;
  logic [4:0]  lsu_addr;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_wren;
  logic [31:0] pending;
  logic        busy;

  always #5 clk = ~clk;

  wb_queue #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .i_clk(clk), .i_rst(rst_n),
    .i_alu_valid(alu_valid), .i_alu_rd_addr(alu_addr), .i_alu_rd_data(alu_data),
    .o_alu_ready(alu_ready),
    .i_lsu_valid(lsu_valid), .i_lsu_rd_addr(lsu_addr), .i_lsu_rd_data(lsu_data),
    .o_lsu_ready(lsu_ready),
    .o_rd_addr(rd_addr), .o_rd_data(rd_data), .o_rd_wren(rd_wren),
    .o_pending(pending), .o_busy(busy)
  );

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  int          starve;
  bit          exp_wren;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;
  int          n_cmp;
  int          n_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", tag, $time, obs, exp);
    end
  endtask

  // One clock cycle: drive, check state-derived outputs, advance model, check write port.
  task automatic cycle(input bit r, input bit av, input logic [4:0] aa, input logic [31:0] ad,
                       input bit lv, input logic [4:0] la, input logic [31:0] ld);
    logic [31:0] exp_pend;
    bit alu_rdy, lsu_rdy, alu_x, lsu_x, byp, was_full_q;
    ent_t e;
    @(negedge clk);
    rst_n = r; alu_valid = av; alu_addr = aa; alu_data = ad;
    lsu_valid = lv; lsu_addr = la; lsu_data = ld;
    #1;
    if (!r) begin
      check("rst_pending", pending, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_alu_ready", {31'd0, alu_ready}, 32'd1);
      check("rst_lsu_ready", {31'd0, lsu_ready}, 32'd1);
      q.delete();
      starve   = 0;
      exp_wren = 1'b0;
      exp_addr = 5'd0;
      exp_data = 32'd0;
    end else begin
      exp_pend = 32'd0;
      foreach (q[i]) exp_pend[q[i].a] = 1'b1;
      alu_rdy = (starve != STARVE_LIMIT);
      lsu_rdy = (q.size() < DEPTH);
      check("pending", pending, exp_pend);
      check("busy", {31'd0, busy}, {31'd0, q.size() != 0});
      check("alu_ready", {31'd0, alu_ready}, {31'd0, alu_rdy});
      check("lsu_ready", {31'd0, lsu_ready}, {31'd0, lsu_rdy});
      alu_x = av && alu_rdy;
      lsu_x = lv && lsu_rdy;
      was_full_q = (q.size() != 0);
      byp = BYPASS && lsu_x && !was_full_q && !alu_x && (la != 5'd0);
      if (alu_x) begin
        exp_wren = (aa != 5'd0);
        exp_addr = aa;
        exp_data = ad;
      end else if (was_full_q) begin
        e = q.pop_front();
        exp_wren = 1'b1;
        exp_addr = e.a;
        exp_data = e.d;
      end else if (byp) begin
        exp_wren = 1'b1;
        exp_addr = la;
        exp_data = ld;
      end else begin
        exp_wren = 1'b0;
      end
      if (lsu_x && la != 5'd0 && !byp) q.push_back('{a: la, d: ld});
      starve = (was_full_q && alu_x) ? starve + 1 : 0;
    end
    @(posedge clk);
    #1;
    check("rd_wren", {31'd0, rd_wren}, {31'd0, exp_wren});
    if (exp_wren || !r) begin
      check("rd_addr", {27'd0, rd_addr}, {27'd0, exp_addr});
      check("rd_data", rd_data, exp_data);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
  endtask

  initial begin
    int pa, pl, amax;
    n_cmp = 0;
    n_err = 0;
    q.delete();
    starve = 0;
    exp_wren = 1'b0;
    exp_addr = 5'd0;
    exp_data = 32'd0;
    rst_n = 1'b0;
    alu_valid = 1'b0; alu_addr = 5'd0; alu_data = 32'd0;
    lsu_valid = 1'b0; lsu_addr = 5'd0; lsu_data = 32'd0;

    // Reset ignores inputs
    cycle(0, 1, 5'd9, 32'h1111_1111, 1, 5'd9, 32'h2222_2222);
    cycle(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    // ALU alone
    cycle(1, 1, 5'd5, 32'h1234_5678, 0, 5'd0, 32'd0);
    idle(1);
    // Single load
    cycle(1, 0, 5'd0, 32'd0, 1, 5'd7, 32'hDEAD_BEEF);
    idle(3);
    // Five loads under continuous ALU traffic
    for (int i = 0; i < 5; i++)
      cycle(1, 1, 5'd10 + 5'(i), 32'hA000_0000 + i, 1, 5'd20 + 5'(i), 32'hB000_0000 + i);
    for (int i = 0; i < 12; i++) cycle(1, 1, 5'd1, 32'hC000_0000 + i, 0, 5'd0, 32'd0);
    idle(6);
    // x0 writes on both sides
    cycle(1, 1, 5'd0, 32'hFFFF_FFFF, 1, 5'd0, 32'hEEEE_EEEE);
    cycle(1, 0, 5'd0, 32'd0, 1, 5'd0, 32'h1);
    idle(2);
    // Same register twice, held behind ALU traffic
    cycle(1, 1, 5'd2, 32'd5, 1, 5'd3, 32'd1);
    cycle(1, 1, 5'd2, 32'd6, 1, 5'd3, 32'd2);
    idle(4);
    // Reset with three buffered entries
    cycle(1, 1, 5'd4, 32'd7, 1, 5'd11, 32'd11);
    cycle(1, 1, 5'd4, 32'd8, 1, 5'd12, 32'd12);
    cycle(1, 1, 5'd4, 32'd9, 1, 5'd13, 32'd13);
    cycle(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    idle(4);

    for (int blk = 0; blk < 16; blk++) begin
      pa   = (blk % 4) * 33;
      pl   = 30 + (blk % 3) * 30;
      amax = (blk % 2) ? 31 : 5;
      for (int c = 0; c < 150; c++) begin
        cycle(($urandom_range(0, 99) != 0),
              ($urandom_range(0, 99) < pa), 5'($urandom_range(0, amax)), $urandom,
              ($urandom_range(0, 99) < pl), 5'($urandom_range(0, amax)), $urandom);
      end
    end
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
